// File: rtl/usb_out_ep_arb_if.sv
// rtl/usb_out_ep_arb_if.sv - requester and OUT-engine signal bundle for the OUT endpoint read-port arbiter
interface usb_out_ep_arb_if #(
    parameter int NUM_OUT_EPS = 4
);
    logic [NUM_OUT_EPS-1:0] req;
    logic [NUM_OUT_EPS-1:0] get;
    logic [NUM_OUT_EPS-1:0] out_ep_data_avail;
    logic [7:0]             out_ep_data;
    logic [NUM_OUT_EPS-1:0] out_ep_grant;
    logic [NUM_OUT_EPS-1:0] out_ep_data_get;
    logic [NUM_OUT_EPS-1:0] grant;
    logic [7:0]             rd_data;
    logic [NUM_OUT_EPS-1:0] rd_valid;
    logic                   busy;

    modport master (
        output req, get, out_ep_data_avail, out_ep_data,
        input  out_ep_grant, out_ep_data_get, grant, rd_data, rd_valid, busy
    );

    modport slave (
        input  req, get, out_ep_data_avail, out_ep_data,
        output out_ep_grant, out_ep_data_get, grant, rd_data, rd_valid, busy
    );
endinterface

// File: rtl/usb_out_ep_arb.sv
// rtl/usb_out_ep_arb.sv - round-robin arbiter and byte sequencer for the shared OUT endpoint read port
module usb_out_ep_arb #(
    parameter int NUM_OUT_EPS = 4,
    parameter int MAX_BURST   = 32
) (
    input logic              clk,
    input logic              reset,
    usb_out_ep_arb_if.slave  bus
);
    localparam logic [3:0] LAST_RST  = 4'(NUM_OUT_EPS - 1);
    localparam logic [5:0] BURST_MAX = 6'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        DRAIN
    } state_t;

    state_t                 state;
    logic [NUM_OUT_EPS-1:0] grant_q;
    logic [NUM_OUT_EPS-1:0] rd_valid_q;
    logic [3:0]             last;
    logic [5:0]             burst_cnt;

    logic [NUM_OUT_EPS-1:0] sel_onehot;
    logic [3:0]             sel_idx;
    logic                   sel_found;
    logic [NUM_OUT_EPS-1:0] get_fwd;
    logic [5:0]             burst_next;
    logic                   owner_req;
    logic                   others_waiting;
    logic                   release_now;

    // First requester strictly after the previous owner, wrapping around.
    always_comb begin
        sel_onehot = '0;
        sel_idx    = last;
        sel_found  = 1'b0;
        for (int k = 1; k <= NUM_OUT_EPS; k++) begin
            if (!sel_found && bus.req[(int'(last) + k) % NUM_OUT_EPS]) begin
                sel_found = 1'b1;
                sel_idx   = 4'((int'(last) + k) % NUM_OUT_EPS);
                sel_onehot[(int'(last) + k) % NUM_OUT_EPS] = 1'b1;
            end
        end
    end

    always_comb begin
        get_fwd        = '0;
        if (state == GRANTED) begin
            get_fwd = bus.get & grant_q & bus.out_ep_data_avail;
        end
        burst_next     = burst_cnt;
        if ((|get_fwd) && (burst_cnt < BURST_MAX)) begin
            burst_next = burst_cnt + 6'd1;
        end
        owner_req      = |(bus.req & grant_q);
        others_waiting = |(bus.req & ~grant_q);
        // The get that completes the burst counts, so the limit is exact.
        release_now    = !owner_req || ((burst_next >= BURST_MAX) && others_waiting);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant_q    <= '0;
            rd_valid_q <= '0;
            last       <= LAST_RST;
            burst_cnt  <= '0;
        end else begin
            rd_valid_q <= get_fwd;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_q   <= sel_onehot;
                        last      <= sel_idx;
                        burst_cnt <= '0;
                        state     <= GRANTED;
                    end
                end
                GRANTED: begin
                    burst_cnt <= burst_next;
                    if (release_now) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Grant held one extra cycle so the last registered byte returns from the owner.
                    grant_q <= '0;
                    state   <= IDLE;
                end
                default: begin
                    grant_q <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant           = grant_q;
    assign bus.out_ep_grant    = grant_q;
    assign bus.out_ep_data_get = get_fwd;
    assign bus.rd_valid        = rd_valid_q;
    assign bus.rd_data         = bus.out_ep_data;
    assign bus.busy            = (state != IDLE);
endmodule

// File: tb/tb_usb_out_ep_arb.sv
// tb/tb_usb_out_ep_arb.sv - scoreboard bench for usb_out_ep_arb with a registered OUT-engine model
module tb_usb_out_ep_arb;
    localparam int N = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [N-1:0]   grant_exp[$];
    logic [N-1:0]   get_exp[$];
    logic [N+7:0]   rd_exp[$];
    logic [N-1:0]   prev_grant;
    logic [7:0]     exp_byte;
    logic [7:0]     eng_byte;
    logic [7:0]     eng_data;

    usb_out_ep_arb_if #(.NUM_OUT_EPS(N)) bus ();

    usb_out_ep_arb #(.NUM_OUT_EPS(N), .MAX_BURST(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine: one-cycle registered read, a fresh byte per pulled get.
    initial eng_byte = 8'h40;
    always @(posedge clk) begin
        if (bus.out_ep_data_get != '0) begin
            eng_data <= eng_byte;
            eng_byte <= eng_byte + 8'd1;
        end
    end
    assign bus.out_ep_data = eng_data;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_get(input logic [N-1:0] mask, input bit with_rd);
        get_exp.push_back(mask);
        if (with_rd) rd_exp.push_back({mask, exp_byte});
        exp_byte = exp_byte + 8'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial prev_grant = '0;
    always @(negedge clk) begin
        logic [N+7:0] e;
        logic [N-1:0] g;
        if (bus.rd_valid !== '0) begin
            if (rd_exp.size() == 0) chk("rd_unexpected", 16'({bus.rd_valid, bus.rd_data}), 16'hFFFF);
            else begin
                e = rd_exp.pop_front();
                chk("rd_valid_data", 16'({bus.rd_valid, bus.rd_data}), 16'(e));
            end
        end
        if (bus.out_ep_data_get !== '0) begin
            if (get_exp.size() == 0) chk("get_unexpected", 16'(bus.out_ep_data_get), 16'hFFFF);
            else begin
                g = get_exp.pop_front();
                chk("data_get", 16'(bus.out_ep_data_get), 16'(g));
            end
        end
        if (bus.grant !== prev_grant) begin
            if (grant_exp.size() == 0) chk("grant_unexpected", 16'(bus.grant), 16'hFFFF);
            else begin
                g = grant_exp.pop_front();
                chk("grant", 16'({bus.out_ep_grant, bus.grant}), 16'({g, g}));
            end
            prev_grant = bus.grant;
        end
    end

    logic [N-1:0] rr_order[4];
    logic [N-1:0] own;

    initial begin
        checks   = 0;
        errors   = 0;
        exp_byte = 8'h40;
        rr_order[0] = 4'b0001;
        rr_order[1] = 4'b0010;
        rr_order[2] = 4'b1000;
        rr_order[3] = 4'b0001;
        reset = 1'b1;
        bus.req = '0;
        bus.get = '0;
        bus.out_ep_data_avail = '0;
        step();
        step();
        chk("rst_grant", 16'(bus.grant), 16'h0);
        chk("rst_busy", 16'(bus.busy), 16'h0);
        chk("rst_rd_valid", 16'(bus.rd_valid), 16'h0);
        reset = 1'b0;

        // Single requester.
        bus.out_ep_data_avail = 4'b0100;
        bus.req = 4'b0100;
        grant_exp.push_back(4'b0100);
        step();
        step();
        bus.get = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            exp_get(4'b0100, 1'b1);
            step();
        end
        bus.get = '0;
        bus.req = '0;
        step();
        #1;
        chk("single_drain_busy", 16'(bus.busy), 16'h1);
        chk("single_drain_grant", 16'(bus.grant), 16'h4);
        grant_exp.push_back(4'b0000);
        step();
        #1;
        chk("single_idle_busy", 16'(bus.busy), 16'h0);

        // Round-robin from reset pointer.
        do_reset();
        bus.out_ep_data_avail = 4'b1111;
        bus.req = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            grant_exp.push_back(rr_order[k]);
            grant_exp.push_back(4'b0000);
        end
        step();
        for (int k = 0; k < 4; k++) begin
            own = rr_order[k];
            bus.get = own;
            bus.req = 4'b1011 & ~own;
            exp_get(own, 1'b1);
            step();
            bus.get = '0;
            bus.req = (k == 3) ? 4'b0000 : 4'b1011;
            step();
            step();
        end

        // Burst limit with a competitor waiting.
        do_reset();
        bus.req = 4'b0011;
        grant_exp.push_back(4'b0001);
        step();
        bus.get = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            exp_get(4'b0001, 1'b1);
            step();
        end
        #1;
        chk("burst_drain_busy", 16'(bus.busy), 16'h1);
        chk("burst_drain_noget", 16'(bus.out_ep_data_get), 16'h0);
        chk("burst_drain_grant", 16'(bus.grant), 16'h1);
        grant_exp.push_back(4'b0000);
        grant_exp.push_back(4'b0010);
        step();
        bus.get = '0;
        #1;
        chk("burst_idle_busy", 16'(bus.busy), 16'h0);
        step();
        bus.req = '0;
        grant_exp.push_back(4'b0000);
        step();
        step();
        step();

        // No competitor: burst limit does not force release.
        do_reset();
        bus.req = 4'b0001;
        grant_exp.push_back(4'b0001);
        step();
        bus.get = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            exp_get(4'b0001, 1'b1);
            step();
        end
        bus.get = '0;
        bus.req = '0;
        #1;
        chk("solo_busy", 16'(bus.busy), 16'h1);
        chk("solo_grant", 16'(bus.grant), 16'h1);
        grant_exp.push_back(4'b0000);
        step();
        step();
        step();

        // Filtering.
        do_reset();
        bus.req = 4'b0001;
        grant_exp.push_back(4'b0001);
        step();
        bus.get = 4'b1000;
        #1;
        chk("filter_nonowner", 16'(bus.out_ep_data_get), 16'h0);
        step();
        bus.get = 4'b0001;
        bus.out_ep_data_avail = 4'b1110;
        #1;
        chk("filter_noavail", 16'(bus.out_ep_data_get), 16'h0);
        step();
        bus.get = '0;
        bus.out_ep_data_avail = 4'b1111;
        bus.req = '0;
        grant_exp.push_back(4'b0000);
        step();
        bus.get = 4'b0001;
        #1;
        chk("filter_drain", 16'(bus.out_ep_data_get), 16'h0);
        step();
        #1;
        chk("filter_idle", 16'(bus.out_ep_data_get), 16'h0);
        bus.get = '0;
        step();
        chk("filter_no_rd", 16'(bus.rd_valid), 16'h0);

        // Asynchronous reset mid-burst.
        do_reset();
        bus.req = 4'b0001;
        grant_exp.push_back(4'b0001);
        step();
        bus.get = 4'b0001;
        exp_get(4'b0001, 1'b1);
        step();
        exp_get(4'b0001, 1'b0);
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_grant", 16'(bus.grant), 16'h0);
        chk("arst_out_ep_grant", 16'(bus.out_ep_grant), 16'h0);
        chk("arst_data_get", 16'(bus.out_ep_data_get), 16'h0);
        chk("arst_rd_valid", 16'(bus.rd_valid), 16'h0);
        chk("arst_busy", 16'(bus.busy), 16'h0);
        grant_exp.push_back(4'b0000);
        bus.get = '0;
        step();
        reset = 1'b0;
        bus.req = 4'b1111;
        grant_exp.push_back(4'b0001);
        step();
        #1;
        chk("arst_first_grant", 16'(bus.grant), 16'h1);
        bus.req = '0;
        grant_exp.push_back(4'b0000);
        step();
        step();
        step();

        chk("grant_q_empty", 16'(grant_exp.size()), 16'h0);
        chk("get_q_empty", 16'(get_exp.size()), 16'h0);
        chk("rd_q_empty", 16'(rd_exp.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_out_ep_arb.md
# usb_out_ep_arb

Arbiter and sequencer for the read side of the USB OUT protocol engine's shared endpoint data buffer. Several endpoint handlers each need to drain their own endpoint, but the engine has a single byte read port, steered by a one-hot grant. This block sits between those handlers and the OUT protocol engine. It grants the port round-robin, forwards byte pulls only for the granted endpoint, and returns each byte with a per-requester valid strobe aligned to the engine's one-cycle registered read.

## Interface
Parameters:
- NUM_OUT_EPS, default 4: number of requesters/endpoints, 1..16.
- MAX_BURST, default 32: gets allowed per grant before a forced release when others wait, 1..63.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_OUT_EPS  requester i wants the read port.
- get  in  NUM_OUT_EPS  requester i pulls one byte; honoured only while granted in GRANTED.
- out_ep_data_avail  in  NUM_OUT_EPS  from the OUT engine: endpoint i has an unread byte.
- out_ep_data  in  8  from the OUT engine: registered buffer read data.
- out_ep_grant  out  NUM_OUT_EPS  to the OUT engine: one-hot endpoint select.
- out_ep_data_get  out  NUM_OUT_EPS  to the OUT engine: one-hot byte pull.
- grant  out  NUM_OUT_EPS  to requesters; always equal to out_ep_grant.
- rd_data  out  8  byte returned to the requester.
- rd_valid  out  NUM_OUT_EPS  one-hot; rd_data is valid for requester i this cycle.
- busy  out  1  high in GRANTED or DRAIN.

## Operation
- States:
  - IDLE: no grant.
  - GRANTED: one-hot owner; gets are forwarded.
  - DRAIN: owner held for one cycle; no gets.
- Round-robin pointer `last`, a 4-bit owner index, resets to NUM_OUT_EPS-1.
- IDLE:
  - If req != 0, select the first set req bit searching upward from last+1 with wrap.
  - Register the selected one-hot into grant, set last to the owner, clear the burst count, and go to GRANTED.
  - Otherwise stay in IDLE.
- GRANTED:
  - out_ep_data_get[i] = get[i] & grant[i] & out_ep_data_avail[i]. This is combinational; all other bits are 0.
  - Each forwarded get increments burst_cnt, which is 6 bits.
  - Release when either condition holds:
    - req[owner] == 0;
    - burst_cnt reaches MAX_BURST and some other req bit is set.
  - On release, go to DRAIN.
  - With no other requester waiting, the burst limit never forces a release; burst_cnt saturates at MAX_BURST.
- DRAIN:
  - grant is held so the engine's read mux stays on the owner while the last byte returns.
  - out_ep_data_get = 0.
  - Next state is IDLE, which clears grant.
- Return path:
  - rd_valid is a register loaded with out_ep_data_get each cycle, so it is the previous cycle's forwarded get.
  - rd_data = out_ep_data, passed combinationally.
- get on a non-owner, get while avail is low, and get in IDLE or DRAIN are all dropped silently. They cause no count change and no rd_valid.
- Reset, asynchronous and mid-operation: all of the following take effect immediately regardless of state.
  - state = IDLE
  - grant, out_ep_grant, out_ep_data_get, rd_valid = 0
  - busy = 0
  - burst_cnt = 0
  - last = NUM_OUT_EPS-1
  - rd_data still follows out_ep_data.
- Simultaneous events:
  - A get on the cycle the release condition becomes true is still forwarded. Its rd_valid appears in the DRAIN cycle.
  - A req that drops and rises again in the same DRAIN is treated as a new request in IDLE.

## Timing
- Latency from req rising in IDLE to grant: 1 cycle (registered).
- Forwarded get to rd_valid/rd_data: 1 cycle.
- Release sequence:
  - Release decision at cycle t.
  - DRAIN at t+1, with grant still high.
  - IDLE at t+2, with grant low.
  - Earliest next grant at t+3.
- Minimum ownership is GRANTED for at least 1 cycle, plus DRAIN for 1 cycle.
- grant, state, burst_cnt, last and rd_valid are flops. busy decodes state.

## Test plan
- Single requester, NUM_OUT_EPS=4:
  - Stimulus: req[2] rises at c0 with avail[2]=1; get[2] at c2..c4; req[2] drops at c5.
  - Required: grant=4'b0100 from c1; out_ep_data_get[2] at c2..c4; rd_valid[2] at c3..c5, with rd_data equal to the engine bytes; DRAIN at c6; grant=0 at c7.
- Round-robin: req=4'b1011 held, each owner releases after 1 get.
  - Required grant order: 0001, 0010, 1000, 0001.
- Burst limit with MAX_BURST=3:
  - Stimulus: req[0] and req[1] high; owner 0 gets every cycle.
  - Required: exactly 3 forwarded gets, then DRAIN, then grant=0010.
  - Repeat with req[1] low: owner 0 keeps the port past 3 gets.
- Filtering:
  - Stimulus: get[3] while grant=0001; get[0] with avail[0]=0; get[0] during DRAIN.
  - Required: out_ep_data_get stays 0 and no rd_valid appears in any of these cases.
- Asynchronous reset:
  - Stimulus: assert reset mid-burst, between clock edges.
  - Required: grant, out_ep_grant, out_ep_data_get, rd_valid and busy all go to 0 immediately.
  - After release, with req=4'b1111, the first grant is 0001.
